// File: rtl/gnn_seq_engine.sv
// gnn_seq_engine
// Two-layer graph neural network engine for an N-node graph with a runtime
// adjacency mask. A single shared datapath handles one node per cycle:
//   L1: a1 = adjacency-weighted sum of node features, h = ReLU(a1 * w1)
//   L2: a2 = adjacency-weighted sum of hidden vectors, y = a2 * w2
// All arithmetic is signed and full precision at the derived widths.
//
// Optional build macro:
//   GNN_L2_RELU_EN - also apply ReLU to the layer-2 results.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   job handshake; inputs are captured on accept
//   x                   node features   x[n][f] at [(n*F+f)*IN_W +: IN_W]
//   adj                 adjacency mask  adj[i*N+j]: node i aggregates node j
//   w1                  layer-1 weights w1[f][h] at [(f*H+h)*W_W +: W_W]
//   w2                  layer-2 weights w2[h][o] at [(h*O+o)*W_W +: W_W]
//   out_valid/out_ready result handshake
//   out_data            results y[n][o] at [(n*O+o)*OUT_W +: OUT_W]
//   busy                engine is not idle
module gnn_seq_engine #(
  parameter int NUM_NODES = 4,
  parameter int NUM_FEAT  = 4,
  parameter int NUM_HID   = 4,
  parameter int NUM_OUT   = 2,
  parameter int IN_W      = 5,
  parameter int W_W       = 5,
  localparam int A1_W  = IN_W + $clog2(NUM_NODES),
  localparam int H_W   = A1_W + W_W + $clog2(NUM_FEAT),
  localparam int A2_W  = H_W + $clog2(NUM_NODES),
  localparam int OUT_W = A2_W + W_W + $clog2(NUM_HID)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_NODES*NUM_FEAT*IN_W-1:0]  x,
  input  logic [NUM_NODES*NUM_NODES-1:0]      adj,
  input  logic [NUM_FEAT*NUM_HID*W_W-1:0]     w1,
  input  logic [NUM_HID*NUM_OUT*W_W-1:0]      w2,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_NODES*NUM_OUT*OUT_W-1:0]  out_data,
  output logic                                busy
);

  localparam int IDX_W = $clog2(NUM_NODES);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             idx_last;

  // Captured job operands.
  logic [NUM_NODES*NUM_NODES-1:0] adj_r;
  logic signed [IN_W-1:0]  x_r  [NUM_NODES][NUM_FEAT];
  logic signed [W_W-1:0]   w1_r [NUM_FEAT][NUM_HID];
  logic signed [W_W-1:0]   w2_r [NUM_HID][NUM_OUT];

  // Layer-1 results and layer-2 results.
  logic signed [H_W-1:0]   h_r  [NUM_NODES][NUM_HID];
  logic signed [OUT_W-1:0] y_r  [NUM_NODES][NUM_OUT];

  // Shared per-node datapath.
  logic [NUM_NODES-1:0]    adj_row;
  logic signed [A1_W-1:0]  a1    [NUM_FEAT];
  logic signed [H_W-1:0]   h_acc [NUM_HID];
  logic signed [H_W-1:0]   h_new [NUM_HID];
  logic signed [A2_W-1:0]  a2    [NUM_HID];
  logic signed [OUT_W-1:0] y_acc [NUM_OUT];
  logic signed [OUT_W-1:0] y_new [NUM_OUT];

  assign idx_last = (idx == IDX_W'(NUM_NODES - 1));
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    adj_row = adj_r[int'(idx)*NUM_NODES +: NUM_NODES];

    for (int unsigned f = 0; f < NUM_FEAT; f++) begin
      a1[f] = '0;
      for (int unsigned j = 0; j < NUM_NODES; j++) begin
        if (adj_row[j]) a1[f] = a1[f] + A1_W'(x_r[j][f]);
      end
    end

    for (int unsigned k = 0; k < NUM_HID; k++) begin
      h_acc[k] = '0;
      for (int unsigned f = 0; f < NUM_FEAT; f++) begin
        h_acc[k] = h_acc[k] + H_W'(a1[f]) * H_W'(w1_r[f][k]);
      end
      h_new[k] = h_acc[k][H_W-1] ? '0 : h_acc[k];
    end

    for (int unsigned k = 0; k < NUM_HID; k++) begin
      a2[k] = '0;
      for (int unsigned j = 0; j < NUM_NODES; j++) begin
        if (adj_row[j]) a2[k] = a2[k] + A2_W'(h_r[j][k]);
      end
    end

    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      y_acc[o] = '0;
      for (int unsigned k = 0; k < NUM_HID; k++) begin
        y_acc[o] = y_acc[o] + OUT_W'(a2[k]) * OUT_W'(w2_r[k][o]);
      end
`ifdef GNN_L2_RELU_EN
      y_new[o] = y_acc[o][OUT_W-1] ? '0 : y_acc[o];
`else
      y_new[o] = y_acc[o];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      for (int unsigned n = 0; n < NUM_NODES; n++) begin
        for (int unsigned k = 0; k < NUM_HID; k++) h_r[n][k] <= '0;
        for (int unsigned o = 0; o < NUM_OUT; o++) y_r[n][o] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            adj_r <= adj;
            for (int unsigned n = 0; n < NUM_NODES; n++)
              for (int unsigned f = 0; f < NUM_FEAT; f++)
                x_r[n][f] <= x[(n*NUM_FEAT+f)*IN_W +: IN_W];
            for (int unsigned f = 0; f < NUM_FEAT; f++)
              for (int unsigned k = 0; k < NUM_HID; k++)
                w1_r[f][k] <= w1[(f*NUM_HID+k)*W_W +: W_W];
            for (int unsigned k = 0; k < NUM_HID; k++)
              for (int unsigned o = 0; o < NUM_OUT; o++)
                w2_r[k][o] <= w2[(k*NUM_OUT+o)*W_W +: W_W];
            idx   <= '0;
            state <= L1;
          end
        end
        L1: begin
          for (int unsigned k = 0; k < NUM_HID; k++) h_r[idx][k] <= h_new[k];
          if (idx_last) begin
            idx   <= '0;
            state <= L2;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        L2: begin
          for (int unsigned o = 0; o < NUM_OUT; o++) y_r[idx][o] <= y_new[o];
          if (idx_last) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_out_node
    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out_unit
      assign out_data[(n*NUM_OUT+o)*OUT_W +: OUT_W] = y_r[n][o];
    end
  end

endmodule
